ccsds_asm_randomizer: RTL and testbench
=======================================

# ccsds_asm_randomizer

Downstream stage of the CCSDS LDPC encoder. It takes each codeword from the encoder's AXI-Stream output, where `tlast` marks the end of a codeword. It applies the CCSDS pseudo-randomizer to the codeword bits, prefixes each codeword with the Attached Sync Marker (ASM), and emits the resulting CADU stream on an AXI-Stream master. Data width matches the encoder's `width` parameter, so the block connects directly to the encoder output.

## Interface
- `width`, 8: parallel bits per beat. Legal values are 1, 2, 4, 8, 16, 32. `width` must divide `asm_len`.
- `asm_len`, 32: ASM length in bits. Legal values are 32 and 64.
- `asm_pattern`, 64'h000000001ACFFC1D: ASM value. The low `asm_len` bits are used, transmitted MSB first.
- `randomize`, 1: 1 enables the randomizer; 0 passes codeword data unchanged.
- `clk`, input, 1: system clock. The block uses this single clock.
- `rst`, input, 1: reset, synchronous and active-high.
- `s_axis_tdata`, input, width: codeword data from the LDPC encoder. The MSB is the earliest bit.
- `s_axis_tvalid`, input, 1: input data valid.
- `s_axis_tlast`, input, 1: marks the last beat of a codeword.
- `s_axis_tready`, output, 1: the block accepts an input beat when this and `s_axis_tvalid` are both high.
- `m_axis_tdata`, output, width: CADU data, ASM first, then the randomized codeword.
- `m_axis_tvalid`, output, 1: output data valid.
- `m_axis_tlast`, output, 1: high on the final beat of each CADU.
- `m_axis_tready`, input, 1: downstream ready.

## Operation
- The FSM has three states: IDLE, ASM, DATA.
  - IDLE → ASM when `s_axis_tvalid` is 1. No input beat is consumed on this transition.
  - In ASM, one ASM beat is loaded into the output register per load opportunity. Beat k carries `asm_pattern` bits [asm_len-1-k·width -: width].
  - ASM → DATA occurs when beat `asm_len/width - 1` is loaded. An internal beat counter resets to 0 on entering ASM.
  - In DATA, `s_axis_tready` = `load`. Each accepted beat is XORed with the randomizer output and loaded into the output register.
  - DATA → IDLE when a beat with `s_axis_tlast` = 1 is accepted.
- Output register:
  - `load` = !`m_axis_tvalid` | `m_axis_tready`.
  - On `load` with a beat available, `m_axis_tdata`, `m_axis_tvalid` = 1 and `m_axis_tlast` update.
  - On `load` with no beat available, `m_axis_tvalid` goes to 0.
  - A beat is available in ASM always, and in DATA only when `s_axis_tvalid` = 1.
  - While `m_axis_tvalid` & !`m_axis_tready`, all `m_axis_*` outputs hold stable.
- `m_axis_tlast` is copied from `s_axis_tlast` on data beats. It is always 0 on ASM beats.
- `s_axis_tready` = 0 in IDLE and ASM.
- Randomizer:
  - LFSR polynomial h(x) = x^8+x^7+x^5+x^3+1, 8-bit state.
  - The state is set to 8'hFF on every ASM → DATA transition.
  - The sequence output begins FF 48 0E C0 9A 0D 70 BC 8E 2C 93 AD A7 B7 46 CE, period 255 bits.
  - The LFSR advances `width` bits per accepted data beat, computed combinationally by unrolling the single-bit step `width` times. It does not advance on stalls or ASM beats.
  - Sequence bit 0 is XORed onto the MSB of the first data beat.
  - With `randomize` = 0, the XOR term is 0. The LFSR may still run.
- The block does not check codeword length; the codeword ends only when `s_axis_tlast` is accepted.

## Timing
- Reset values: `m_axis_tvalid` = 0, `m_axis_tlast` = 0, `m_axis_tdata` = 0, `s_axis_tready` = 0, state = IDLE, LFSR = 8'hFF, beat counter = 0.
- Reset asserted mid-frame discards the partial CADU. Outputs take their reset values in the cycle after the `rst` edge. The upstream encoder is reset together with this block.
- Start-up: `s_axis_tvalid` rises in cycle n while in IDLE. The state is ASM in n+1. ASM beat 0 is visible on `m_axis_*` in n+2 if `m_axis_tready` stays high.
- Input-to-output latency is 1 cycle: a data beat accepted in cycle n appears in cycle n+1.
- Per-CADU overhead with `m_axis_tready` held high:
  - `asm_len/width` ASM beats.
  - Plus 1 idle cycle between CADUs (the IDLE → ASM transition).
  - Back-to-back CADUs therefore show exactly one `m_axis_tvalid` = 0 cycle between the `tlast` beat and the next ASM beat 0.
- No combinational path exists from `m_axis_tready` to `m_axis_tdata`. `s_axis_tready` does depend combinationally on `m_axis_tready` in DATA.
- If `s_axis_tvalid` drops mid-codeword, `m_axis_tvalid` deasserts after the current beat drains. The LFSR and state hold until the next accepted beat.

## Test plan
- **Basic CADU:** width=8, asm_len=32, randomize=1, one 160-byte all-zero codeword with `tlast` on byte 160, `m_axis_tready`=1.
  - Output: 1A CF FC 1D FF 48 0E C0 9A 0D 70 BC …, 164 beats total.
  - `m_axis_tlast` is high only on beat 164, with data equal to randomizer byte 160 (sequence byte 159 mod 255).
- **Reseed:** two consecutive all-zero codewords.
  - The second CADU's data also begins FF 48 0E C0.
  - Exactly one invalid cycle appears between the CADUs.
- **Randomizer bypass:** randomize=0 with input bytes 00, 01, …, 9F.
  - Output: 1A CF FC 1D 00 01 … 9F unchanged.
- **Backpressure:** `m_axis_tready` toggled at random, including deasserted during ASM beat 2 and during data beat 50.
  - The output stream is byte-identical to the basic scenario.
  - `m_axis_*` stays stable whenever stalled.
  - `s_axis_tready` is 0 while stalled.
- **64-bit ASM and wider bus:** asm_len=64, asm_pattern=64'h034776C7272895B0, width=32.
  - The first two beats are 034776C7, 272895B0.
  - The first data beat (all-zero input) is FF480EC0.
- **Reset mid-frame:** `rst` asserted for 1 cycle during data beat 80.
  - The next cycle shows `m_axis_tvalid`=0 and `s_axis_tready`=0.
  - A following codeword produces a complete CADU starting 1A CF FC 1D FF 48.

Source files
------------

// File: rtl/ccsds_asm_randomizer.sv
// rtl/ccsds_asm_randomizer.sv - CCSDS ASM insertion and pseudo-randomizer for LDPC codewords
module ccsds_asm_randomizer #(
    parameter int          width        = 8,
    parameter int          asm_len      = 32,
    parameter logic [63:0] asm_pattern  = 64'h000000001ACFFC1D,
    parameter bit          randomize_en = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] s_axis_tdata,
    input  logic             s_axis_tvalid,
    input  logic             s_axis_tlast,
    output logic             s_axis_tready,
    output logic [width-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    output logic             m_axis_tlast,
    input  logic             m_axis_tready
);
    localparam int ASM_BEATS = asm_len / width;
    localparam int CNT_W     = $clog2(ASM_BEATS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ASM_BEATS - 1);
    // ASM left-aligned in 64 bits so beat k is always the top slice after a shift
    localparam logic [63:0] ASM_LEFT = asm_pattern << (64 - asm_len);

    typedef enum logic [1:0] {ST_IDLE, ST_ASM, ST_DATA} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       lfsr_q, lfsr_d;
    logic [width-1:0] tdata_q, tdata_d;
    logic             tvalid_q, tvalid_d;
    logic             tlast_q, tlast_d;
    logic             load;
    logic [7:0]       lfsr_adv;
    logic [width-1:0] prbs;
    logic [63:0]      asm_word;

    // Output register may take a new beat when empty or being drained this cycle
    assign load          = !tvalid_q || m_axis_tready;
    assign s_axis_tready = (state_q == ST_DATA) && load;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;

    // Unrolled LFSR: width sequence bits (earliest at the MSB) and the state after them
    always_comb begin
        lfsr_adv = lfsr_q;
        prbs     = '0;
        for (int i = width - 1; i >= 0; i--) begin
            prbs[i]  = lfsr_adv[7];
            lfsr_adv = {lfsr_adv[6:0], lfsr_adv[7] ^ lfsr_adv[4] ^ lfsr_adv[2] ^ lfsr_adv[0]};
        end
    end

    // Next-state and output-register load decisions
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        lfsr_d   = lfsr_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        asm_word = ASM_LEFT << (int'(cnt_q) * width);
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    tvalid_d = 1'b0;
                end
                if (s_axis_tvalid) begin
                    state_d = ST_ASM;
                    cnt_d   = '0;
                end
            end
            ST_ASM: begin
                if (load) begin
                    tdata_d  = asm_word[63 -: width];
                    tvalid_d = 1'b1;
                    tlast_d  = 1'b0;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_DATA;
                        cnt_d   = '0;
                        lfsr_d  = 8'hFF;
                    end
                end
            end
            ST_DATA: begin
                if (load) begin
                    if (s_axis_tvalid) begin
                        tdata_d  = s_axis_tdata ^ (randomize_en ? prbs : '0);
                        tvalid_d = 1'b1;
                        tlast_d  = s_axis_tlast;
                        lfsr_d   = lfsr_adv;
                        if (s_axis_tlast) begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        tvalid_d = 1'b0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM, beat counter, LFSR and registered stream outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            lfsr_q   <= 8'hFF;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lfsr_q   <= lfsr_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
        end
    end
endmodule

// File: tb/tb_ccsds_asm_randomizer.sv
// tb/tb_ccsds_asm_randomizer.sv - scoreboard bench for ccsds_asm_randomizer
module tb_ccsds_asm_randomizer;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] drv_tdata;
    logic        drv_tvalid;
    logic        drv_tlast;
    logic        m_tready;
    logic [1:0]  sel;
    bit          bp_en;
    bit          gap_chk;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  m_tdata0, m_tdata1;
    logic [31:0] m_tdata2;
    logic        m_tvalid0, m_tvalid1, m_tvalid2;
    logic        m_tlast0, m_tlast1, m_tlast2;
    logic        s_tready0, s_tready1, s_tready2;

    logic [31:0] md;
    logic        mv, ml, st;

    logic [32:0] exp_q[$];
    bit          seq[255];
    int          out_idx = 0;

    always #5 clk = ~clk;

    ccsds_asm_randomizer #(.width(8), .asm_len(32), .asm_pattern(64'h1ACFFC1D), .randomize_en(1'b1)) u_rand8 (
        .clk(clk), .rst(rst),
        .s_axis_tdata(drv_tdata[7:0]), .s_axis_tvalid(drv_tvalid && (sel == 2'd0)),
        .s_axis_tlast(drv_tlast), .s_axis_tready(s_tready0),
        .m_axis_tdata(m_tdata0), .m_axis_tvalid(m_tvalid0), .m_axis_tlast(m_tlast0),
        .m_axis_tready(m_tready));

    ccsds_asm_randomizer #(.width(8), .asm_len(32), .asm_pattern(64'h1ACFFC1D), .randomize_en(1'b0)) u_bypass8 (
        .clk(clk), .rst(rst),
        .s_axis_tdata(drv_tdata[7:0]), .s_axis_tvalid(drv_tvalid && (sel == 2'd1)),
        .s_axis_tlast(drv_tlast), .s_axis_tready(s_tready1),
        .m_axis_tdata(m_tdata1), .m_axis_tvalid(m_tvalid1), .m_axis_tlast(m_tlast1),
        .m_axis_tready(m_tready));

    ccsds_asm_randomizer #(.width(32), .asm_len(64), .asm_pattern(64'h034776C7272895B0), .randomize_en(1'b1)) u_rand32 (
        .clk(clk), .rst(rst),
        .s_axis_tdata(drv_tdata), .s_axis_tvalid(drv_tvalid && (sel == 2'd2)),
        .s_axis_tlast(drv_tlast), .s_axis_tready(s_tready2),
        .m_axis_tdata(m_tdata2), .m_axis_tvalid(m_tvalid2), .m_axis_tlast(m_tlast2),
        .m_axis_tready(m_tready));

    always_comb begin
        md = {24'b0, m_tdata0};
        mv = m_tvalid0;
        ml = m_tlast0;
        st = s_tready0;
        if (sel == 2'd1) begin
            md = {24'b0, m_tdata1};
            mv = m_tvalid1;
            ml = m_tlast1;
            st = s_tready1;
        end else if (sel == 2'd2) begin
            md = m_tdata2;
            mv = m_tvalid2;
            ml = m_tlast2;
            st = s_tready2;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic int cur_w();
        return (sel == 2'd2) ? 32 : 8;
    endfunction

    function automatic logic [31:0] cur_mask();
        return (sel == 2'd2) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    endfunction

    function automatic int asm_beats();
        return (sel == 2'd2) ? 2 : 4;
    endfunction

    // ASM beat k: slice k of the pattern, MSB first
    function automatic logic [31:0] asm_beat(input int k);
        logic [63:0] p;
        int len;
        len = (sel == 2'd2) ? 64 : 32;
        p = (sel == 2'd2) ? 64'h034776C7272895B0 : 64'h000000001ACFFC1D;
        p = p >> (len - (k + 1) * cur_w());
        return p[31:0] & cur_mask();
    endfunction

    // Randomizer bits for data beat j, earliest sequence bit at the MSB
    function automatic logic [31:0] rnd(input int j, input int w);
        logic [31:0] r;
        r = '0;
        for (int b = 0; b < w; b++) r = (r << 1) | 32'(seq[(j * w + b) % 255]);
        return r;
    endfunction

    task automatic wait_accept();
        int t;
        bit ok;
        t = 0;
        ok = 1'b0;
        while (!ok) begin
            @(negedge clk);
            ok = st;
            @(posedge clk);
            #1;
            t++;
            if (t > 2000) begin
                chk("accept_timeout", 64'(t), 64'd2000);
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
        end
    endtask

    // mode 0: zeros, 1: counting, 2: random; abort_at >= 0 resets during that data beat
    task automatic send_frame(input int n, input int mode, input int abort_at, input bit gaps);
        logic [31:0] d;
        logic [31:0] r;
        for (int k = 0; k < asm_beats(); k++) exp_q.push_back({1'b0, asm_beat(k)});
        for (int j = 0; j < n; j++) begin
            d = (mode == 0) ? 32'h0 : (mode == 1) ? 32'(j) : $urandom;
            d = d & cur_mask();
            if (j == abort_at) begin
                drv_tdata = d;
                drv_tlast = 1'b0;
                drv_tvalid = 1'b1;
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                drv_tvalid = 1'b0;
                @(negedge clk);
                chk("rst_mid_m_tvalid", 64'(mv), 64'd0);
                chk("rst_mid_s_tready", 64'(st), 64'd0);
                chk("rst_mid_queue_empty", 64'(exp_q.size()), 64'd0);
                exp_q.delete();
                @(posedge clk);
                #1;
                return;
            end
            r = (sel == 2'd1) ? 32'h0 : rnd(j, cur_w());
            exp_q.push_back({(j == n - 1), (d ^ r) & cur_mask()});
            if (gaps && ($urandom_range(0, 5) == 0)) begin
                drv_tvalid = 1'b0;
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
            drv_tdata = d;
            drv_tlast = (j == n - 1);
            drv_tvalid = 1'b1;
            wait_accept();
        end
        drv_tvalid = 1'b0;
        drv_tlast = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 5000) begin
            @(posedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Downstream ready: random when backpressure is on, forcing a stall on output beats 2 and 54
    initial begin
        int forced;
        forced = -1;
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (!bp_en) m_tready = 1'b1;
            else if (mv && (out_idx == 2 || out_idx == 54) && forced != out_idx) begin
                m_tready = 1'b0;
                forced = out_idx;
            end else m_tready = ($urandom_range(0, 2) != 0);
            if (out_idx == 0) forced = -1;
        end
    end

    // Monitor: scoreboard pop on handshake, stall stability, inter-CADU gap
    initial begin
        logic [32:0] e;
        bit prev_stall, prev_rst, armed;
        logic [31:0] prev_d;
        logic prev_l;
        int gap;
        prev_stall = 0; prev_rst = 1; armed = 0; gap = 0; prev_d = 0; prev_l = 0;
        forever begin
            @(negedge clk);
            if (prev_stall && !prev_rst) chk("stall_hold", {31'b0, mv, ml, md}, {31'b0, 1'b1, prev_l, prev_d});
            if (mv && !m_tready) chk("stall_s_tready", 64'(st), 64'd0);
            if (armed) begin
                if (!mv) gap++;
                else begin
                    chk("cadu_gap", 64'(gap), 64'd1);
                    armed = 0;
                end
            end
            if (mv && m_tready) begin
                if (exp_q.size() == 0) chk("unexpected_beat", {31'b0, ml, md}, 64'h1_0000_0000_0000);
                else begin
                    e = exp_q.pop_front();
                    chk($sformatf("beat%0d", out_idx), {31'b0, ml, md}, {31'b0, e});
                end
                if (ml) begin
                    armed = gap_chk;
                    gap = 0;
                    out_idx = 0;
                end else out_idx++;
            end
            if (rst) begin
                out_idx = 0;
                armed = 0;
            end
            prev_stall = mv && !m_tready;
            prev_d = md;
            prev_l = ml;
            prev_rst = rst;
        end
    end

    initial begin
        rst = 1'b1;
        drv_tvalid = 1'b0;
        drv_tdata = '0;
        drv_tlast = 1'b0;
        sel = 2'd0;
        bp_en = 0;
        gap_chk = 0;
        for (int n = 0; n < 255; n++) seq[n] = (n < 8) ? 1'b1 : (seq[n-1] ^ seq[n-3] ^ seq[n-5] ^ seq[n-8]);
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            sel = 2'(i);
            #1;
            chk($sformatf("reset_tvalid%0d", i), 64'(mv), 64'd0);
            chk($sformatf("reset_tlast%0d", i), 64'(ml), 64'd0);
            chk($sformatf("reset_tdata%0d", i), 64'(md), 64'd0);
            chk($sformatf("reset_s_tready%0d", i), 64'(st), 64'd0);
        end
        sel = 2'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        send_frame(160, 0, -1, 0);
        drain();

        gap_chk = 1;
        send_frame(160, 0, -1, 0);
        send_frame(160, 0, -1, 0);
        gap_chk = 0;
        drain();

        sel = 2'd1;
        send_frame(160, 1, -1, 0);
        drain();

        sel = 2'd0;
        bp_en = 1;
        send_frame(160, 0, -1, 0);
        for (int i = 0; i < 3; i++) send_frame($urandom_range(1, 60), 2, -1, 1);
        drain();
        bp_en = 0;
        drain();

        sel = 2'd2;
        send_frame(40, 0, -1, 0);
        drain();
        bp_en = 1;
        for (int i = 0; i < 2; i++) send_frame($urandom_range(1, 30), 2, -1, 1);
        drain();
        bp_en = 0;
        drain();

        sel = 2'd0;
        send_frame(160, 0, 80, 0);
        send_frame(160, 0, -1, 0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
